// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed, big-endian data memory with a valid/ready
// request channel, programmable access latency and misalignment reporting.
// Storage is split into eight byte lanes; an aligned access never crosses a
// doubleword row, so each byte of an access lands in a distinct lane.
module data_mem_sized #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic        resp_valid,
    output logic [63:0] read_data,
    output logic        misaligned
);

    localparam int ROW_W = (ADDR_BITS > 3) ? ADDR_BITS - 3 : 1;
    localparam int ROWS  = 1 << (ADDR_BITS - 3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   resp_valid_q;
    logic                   misaligned_q;
    logic [63:0]            read_data_q;

    // Request fields captured at acceptance; later input changes are ignored.
    logic [ADDR_BITS-1:0]   addr_q;
    logic [1:0]             size_q;
    logic                   write_q;
    logic                   uns_q;
    logic [63:0]            wdata_q;

    logic [ROW_W-1:0]       row_idx;
    logic [2:0]             off;
    logic [3:0]             n_bytes;
    logic [3:0]             shamt;
    logic                   mis;
    logic                   do_access;
    logic                   do_write;
    logic [63:0]            wd_shift;
    logic [63:0]            row_be;
    logic [63:0]            ld_raw;
    logic [63:0]            ld_ext;
    logic [7:0]             lane_rd [8];
    logic                   unused_addr_bits;

    // Only the low ADDR_BITS of the address select a byte; the rest alias.
    assign unused_addr_bits = ^address[63:ADDR_BITS];

    assign row_idx   = ROW_W'(addr_q >> 3);
    assign off       = addr_q[2:0];
    assign n_bytes   = 4'd1 << size_q;
    // Distance (in bytes) from the low end of the row to the last accessed byte.
    assign shamt     = 4'd8 - {1'b0, off} - n_bytes;
    assign mis       = ((size_q == 2'd1) && addr_q[0]) ||
                       ((size_q == 2'd2) && (addr_q[1:0] != 2'b00)) ||
                       ((size_q == 2'd3) && (off != 3'b000));
    assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
    assign do_write  = do_access && write_q && !mis;
    assign wd_shift  = wdata_q << {shamt, 3'b000};

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign misaligned = misaligned_q;
    assign read_data  = read_data_q;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] mem_q [ROWS];
            logic       lane_en;

            // Lane gi holds the byte at row*8+gi; lane 0 is the most significant.
            assign lane_en = (4'(gi) >= {1'b0, off}) && (4'(gi) < ({1'b0, off} + n_bytes));

            // Byte-lane write for aligned stores only.
            always_ff @(posedge clk) begin
                if (do_write && lane_en) begin
                    mem_q[row_idx] <= wd_shift[63-8*gi -: 8];
                end
            end

            assign lane_rd[gi] = mem_q[row_idx];
        end
    endgenerate

    // Assemble the addressed row big-endian and extend the selected bytes.
    always_comb begin
        row_be = 64'd0;
        for (int i = 0; i < 8; i++) begin
            row_be[63-8*i -: 8] = lane_rd[i];
        end
        ld_raw = row_be >> {shamt, 3'b000};
        case (size_q)
            2'd0:    ld_ext = uns_q ? {56'd0, ld_raw[7:0]}  : {{56{ld_raw[7]}},  ld_raw[7:0]};
            2'd1:    ld_ext = uns_q ? {48'd0, ld_raw[15:0]} : {{48{ld_raw[15]}}, ld_raw[15:0]};
            2'd2:    ld_ext = uns_q ? {32'd0, ld_raw[31:0]} : {{32{ld_raw[31]}}, ld_raw[31:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    // Capture request fields when a request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && req_valid && !reset) begin
            addr_q  <= address[ADDR_BITS-1:0];
            size_q  <= req_size;
            write_q <= req_write;
            uns_q   <= req_unsigned;
            wdata_q <= write_data;
        end
    end

    // Control FSM: accept, count down the latency, then pulse the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            read_data_q  <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    misaligned_q <= 1'b0;
                    if (req_valid) begin
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        resp_valid_q <= 1'b1;
                        misaligned_q <= mis;
                        if (!write_q) begin
                            read_data_q <= mis ? 64'd0 : ld_ext;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    misaligned_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    misaligned_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Testbench for data_mem_sized: directed test-plan steps followed by random
// traffic, checked against a byte-array reference model.
module tb_data_mem_sized;

    localparam int AB  = 10;
    localparam int LAT = 3;
    localparam int CAP = 1 << AB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] address = 64'd0;
    logic [63:0] write_data = 64'd0;
    logic        resp_valid;
    logic [63:0] read_data;
    logic        misaligned;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  mem_m [CAP];
    logic [63:0] exp_rd = 64'd0;

    data_mem_sized #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .write_data(write_data), .resp_valid(resp_valid),
        .read_data(read_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: update memory / expected load value for one request.
    task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd, output logic e_mis);
        int n;
        int a;
        logic [63:0] v;
        n = 1 << sz;
        a = int'(addr % CAP);
        e_mis = (a % n) != 0;
        if (e_mis) begin
            if (!wr) exp_rd = 64'd0;
        end else if (wr) begin
            for (int i = 0; i < n; i++) mem_m[(a + i) % CAP] = 8'(wd >> (8 * (n - 1 - i)));
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 64'(mem_m[(a + i) % CAP]);
            if (n < 8 && !uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
            exp_rd = v;
        end
    endtask

    // One complete transaction; called #1 after a rising edge with the DUT idle.
    task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic chk_lit, input logic [63:0] lit);
        logic e_mis;
        int cyc;
        check("ready_idle", 64'(req_ready), 64'd1);
        model(wr, sz, uns, addr, wd, e_mis);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        address = addr; write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        write_data = {$urandom(), $urandom()};
        address = {$urandom(), $urandom()};
        req_unsigned = ~uns;
        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(LAT));
        check("misaligned", 64'(misaligned), 64'(e_mis));
        check("read_data", read_data, exp_rd);
        if (chk_lit) check("read_data_lit", read_data, lit);
        $display("xact wr=%0d sz=%0d uns=%0d addr=%h wd=%h -> rd=%h mis=%0d",
                 wr, sz, uns, addr, wd, read_data, misaligned);
        @(posedge clk); #1;
        check("resp_pulse", 64'(resp_valid), 64'd0);
        check("mis_idle", 64'(misaligned), 64'd0);
        check("ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a64;
        logic e_mis;
        for (int i = 0; i < CAP; i++) mem_m[i] = 8'd0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp", 64'(resp_valid), 64'd0);
        check("rst_mis", 64'(misaligned), 64'd0);
        check("rst_rd", read_data, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Doubleword/byte basics
        xact(1, 2'd3, 0, 64'h10, 64'h0123456789ABCDEF, 0, 0);
        xact(0, 2'd3, 0, 64'h10, 0, 1, 64'h0123456789ABCDEF);
        xact(0, 2'd0, 1, 64'h10, 0, 1, 64'h01);
        xact(0, 2'd0, 0, 64'h17, 0, 1, 64'hFFFFFFFFFFFFFFEF);
        xact(0, 2'd0, 1, 64'h17, 0, 1, 64'hEF);
        // Halfword store into the middle
        xact(1, 2'd1, 0, 64'h12, 64'hBEEF, 0, 0);
        xact(0, 2'd1, 1, 64'h12, 0, 1, 64'hBEEF);
        xact(0, 2'd1, 0, 64'h12, 0, 1, 64'hFFFFFFFFFFFFBEEF);
        xact(0, 2'd3, 0, 64'h10, 0, 1, 64'h0123BEEF89ABCDEF);
        xact(0, 2'd2, 1, 64'h14, 0, 1, 64'h89ABCDEF);
        xact(0, 2'd2, 0, 64'h14, 0, 1, 64'hFFFFFFFF89ABCDEF);
        // Misaligned accesses
        xact(0, 2'd2, 0, 64'h16, 0, 1, 64'd0);
        xact(1, 2'd3, 0, 64'h13, ~64'd0, 1, 64'd0);
        xact(0, 2'd3, 0, 64'h10, 0, 1, 64'h0123BEEF89ABCDEF);

        // Latency window with req_valid held high throughout
        check("ready_hold", 64'(req_ready), 64'd1);
        model(0, 2'd3, 0, 64'h10, 0, e_mis);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; address = 64'h10;
        @(posedge clk); #1;
        for (int k = 0; k < LAT; k++) begin
            check("hold_busy_ready", 64'(req_ready), 64'd0);
            check("hold_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        check("hold_resp", 64'(resp_valid), 64'd1);
        check("hold_resp_ready", 64'(req_ready), 64'd0);
        check("hold_rd", read_data, 64'h0123BEEF89ABCDEF);
        @(posedge clk); #1;
        check("hold_ready_back", 64'(req_ready), 64'd1);
        check("hold_resp_end", 64'(resp_valid), 64'd0);
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("hold_no_double", 64'(resp_valid), 64'd0);
        end

        // Reset in the middle of a store
        xact(1, 2'd3, 0, 64'h20, 64'h5555555555555555, 0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; address = 64'h20;
        write_data = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rd = 64'd0;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_resp", 64'(resp_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check("mid_rst_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        xact(0, 2'd3, 0, 64'h20, 0, 1, 64'h5555555555555555);

        // Top of memory and address aliasing
        xact(1, 2'd3, 0, 64'h3F8, 64'h1122334455667788, 0, 0);
        xact(0, 2'd3, 0, 64'h3F8, 0, 1, 64'h1122334455667788);
        xact(1, 2'd0, 0, 64'h400, 64'h99, 0, 0);
        xact(0, 2'd0, 1, 64'h000, 0, 1, 64'h99);

        // Random traffic over a small region, with random aliasing upper bits
        for (int r = 0; r < 16; r++) begin
            xact(1, 2'd3, 0, 64'(r * 8), {$urandom(), $urandom()}, 0, 0);
        end
        for (int r = 0; r < 60; r++) begin
            a64 = {$urandom(), $urandom()};
            a64[9:0] = 10'($urandom_range(0, 127));
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a64, {$urandom(), $urandom()}, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
